hamming_lane_rx: RTL and testbench



---
 rtl/hamming_lane_rx.sv | 142 ++++++++++++++
 tb/tb_hamming_lane_rx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_lane_rx.sv
// Receive lane: deserialises Hamming(7,4) codewords, corrects single-bit
// errors and queues decoded nibbles in a small valid/ready FIFO.
module hamming_lane_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     strobe,
    input  logic                     s_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [3:0]               out_data,
    output logic                     out_corr,
    output logic                     overflow,
    output logic [CNT_W-1:0]         corr_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {
        IDLE,
        PEND
    } dec_state_e;

    logic [2:0]       idx_q, idx_d;
    logic [6:0]       shift_q, shift_d;
    logic [6:0]       word_q, word_d;
    dec_state_e       dec_q, dec_d;
    logic             cap_last;

    logic [2:0]       syn;
    logic [6:0]       flip;
    logic [6:0]       fixed;
    logic [3:0]       dec_data;
    logic             dec_corr;

    logic [4:0]       mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push, pop, full, accept;

    assign cap_last = (idx_q == 3'd6);

    // Capture next-state: shift bits in on strobe, hand full frame to decode.
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        dec_d   = IDLE;
        if (strobe) begin
            shift_d[idx_q] = s_in;
            if (cap_last) begin
                word_d = {s_in, shift_q[5:0]};
                dec_d  = PEND;
                idx_d  = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // Syndrome and single-bit correction of the pending codeword.
    always_comb begin
        syn[0] = word_q[0] ^ word_q[2] ^ word_q[4] ^ word_q[6];
        syn[1] = word_q[1] ^ word_q[2] ^ word_q[5] ^ word_q[6];
        syn[2] = word_q[3] ^ word_q[4] ^ word_q[5] ^ word_q[6];
        flip   = '0;
        for (int i = 0; i < 7; i++) begin
            flip[i] = (syn == 3'(i + 1));
        end
        fixed    = word_q ^ flip;
        dec_data = {fixed[6], fixed[5], fixed[4], fixed[2]};
        dec_corr = |syn;
    end

    // FIFO control: a push wins a full FIFO only when a pop frees a slot.
    always_comb begin
        push    = (dec_q == PEND);
        pop     = out_valid & out_ready;
        full    = (level_q == LW'(DEPTH));
        accept  = push & (~full | pop);
        level_d = level_q;
        if (accept && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!accept && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // State registers for capture, decode and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            dec_q   <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            dec_q   <= dec_d;
            level_q <= level_d;
            if (accept) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push && !accept) begin
                ovf_q <= 1'b1;
            end
            if (accept && dec_corr && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only visible while occupancy is nonzero.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_q] <= {dec_corr, dec_data};
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_q][3:0] : 4'd0;
    assign out_corr   = out_valid ? mem_q[rd_q][4] : 1'b0;
    assign overflow   = ovf_q;
    assign corr_count = cnt_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_hamming_lane_rx.sv
// Bench for hamming_lane_rx: vector table, directed corner sequences and
// randomized frames against a queue-level reference model.
module tb_hamming_lane_rx;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             strobe = 1'b0;
    logic             s_in = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [3:0]       out_data;
    logic             out_corr;
    logic             overflow;
    logic [CNT_W-1:0] corr_count;
    logic [2:0]       fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    hamming_lane_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .strobe     (strobe),
        .s_in       (s_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_corr   (out_corr),
        .overflow   (overflow),
        .corr_count (corr_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model state (queue of {corr,data})
    logic [4:0] mq[$];
    int         m_idx = 0;
    logic [6:0] m_frame = '0;
    bit         m_pend = 0;
    logic [4:0] m_pval = '0;
    bit         m_ovf = 0;
    int         m_cnt = 0;
    bit         rand_ready = 0;

    // w[i] holds wire position i+1
    function automatic logic [6:0] encode(logic [3:0] d);
        logic [6:0] w;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        w[0] = d[0] ^ d[1] ^ d[3];
        w[1] = d[0] ^ d[2] ^ d[3];
        w[3] = d[1] ^ d[2] ^ d[3];
        return w;
    endfunction

    // Syndrome = XOR of the positions holding a 1
    function automatic logic [4:0] m_decode(logic [6:0] w);
        int s = 0;
        for (int p = 1; p <= 7; p++)
            if (w[p-1]) s = s ^ p;
        if (s != 0) w[s-1] = ~w[s-1];
        return {s != 0, w[6], w[5], w[4], w[2]};
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         do_pop;
        bit         room;
        logic [4:0] tmp;
        if (rst) begin
            mq.delete();
            m_idx = 0;
            m_frame = '0;
            m_pend = 0;
            m_ovf = 0;
            m_cnt = 0;
        end else begin
            do_pop = (mq.size() != 0) && out_ready;
            room = (mq.size() < DEPTH) || do_pop;
            if (do_pop) tmp = mq.pop_front();
            if (m_pend) begin
                if (room) begin
                    mq.push_back(m_pval);
                    if (m_pval[4] && m_cnt < CMAX) m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
            m_pend = 0;
            if (strobe) begin
                m_frame[m_idx] = s_in;
                m_idx++;
                if (m_idx == 7) begin
                    m_pend = 1;
                    m_pval = m_decode(m_frame);
                    m_idx = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [4:0] head;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_step();
        @(negedge clk);
        head = (mq.size() != 0) ? mq[0] : 5'd0;
        check("m_valid", int'(out_valid), int'(mq.size() != 0));
        check("m_data", int'(out_data), int'(head[3:0]));
        check("m_corr", int'(out_corr), int'(head[4]));
        check("m_level", int'(fifo_level), mq.size());
        check("m_ovf", int'(overflow), int'(m_ovf));
        check("m_count", int'(corr_count), m_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        strobe = 1'b0;
        s_in = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // gap: 0 none, 1 one idle cycle before each bit, 2 random idles
    task automatic send_frame(logic [6:0] w, int gap);
        int n;
        for (int i = 0; i < 7; i++) begin
            n = (gap == 1) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
            for (int k = 0; k < n; k++) begin
                strobe = 1'b0;
                s_in = 1'($urandom_range(0, 1));
                tick();
            end
            strobe = 1'b1;
            s_in = w[i];
            tick();
        end
        strobe = 1'b0;
        s_in = 1'b0;
    endtask

    typedef struct {
        logic [6:0] w;
        logic [3:0] data;
        logic       corr;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [6:0] w;
        logic [3:0] d;
        int         e;

        // {pos7..pos1}
        vt[0] = '{7'b1010101, 4'b1011, 1'b0};
        vt[1] = '{7'b1000101, 4'b1011, 1'b1};
        vt[2] = '{7'b1010100, 4'b1011, 1'b1};
        vt[3] = '{7'b0000000, 4'b0000, 1'b0};
        vt[4] = '{7'b0110011, 4'b0110, 1'b0};
        vt[5] = '{7'b0111011, 4'b0110, 1'b1};
        vt[6] = '{7'b0010101, 4'b1011, 1'b1};
        vt[7] = '{7'b1010110, 4'b1010, 1'b1};

        @(negedge clk);
        do_reset();
        check("rst_valid", int'(out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_count", int'(corr_count), 0);
        check("rst_ovf", int'(overflow), 0);

        foreach (vt[i]) begin
            send_frame(vt[i].w, 0);
            check("vec_not_yet", int'(out_valid), 0);
            tick();
            check("vec_valid", int'(out_valid), 1);
            check("vec_data", int'(out_data), int'(vt[i].data));
            check("vec_corr", int'(out_corr), int'(vt[i].corr));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Idle lane, strobe on alternate cycles
        do_reset();
        send_frame(7'b0, 1);
        check("gap_not_yet", int'(out_valid), 0);
        tick();
        check("gap_valid", int'(out_valid), 1);
        check("gap_data", int'(out_data), 0);
        check("gap_corr", int'(out_corr), 0);

        // Backpressure overflow, then ordered drain
        do_reset();
        for (int k = 1; k <= 5; k++) send_frame(encode(4'(k)), 0);
        tick();
        check("bp_level", int'(fifo_level), 4);
        check("bp_ovf", int'(overflow), 1);
        for (int k = 1; k <= 4; k++) begin
            check("bp_order", int'(out_data), k);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("bp_empty", int'(fifo_level), 0);
        check("bp_ovf_sticky", int'(overflow), 1);

        // Full FIFO with pop on the push edge
        do_reset();
        for (int k = 1; k <= 5; k++) send_frame(encode(4'(k)), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fp_level", int'(fifo_level), 4);
        check("fp_ovf", int'(overflow), 0);
        check("fp_head", int'(out_data), 2);

        // Reset mid-frame
        do_reset();
        strobe = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_in = 1'b1;
            tick();
        end
        do_reset();
        send_frame(7'b0110011, 0);
        tick();
        tick();
        check("rmf_level", int'(fifo_level), 1);
        check("rmf_data", int'(out_data), 6);
        check("rmf_count", int'(corr_count), 0);

        // Corrected-word counter saturation
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < CMAX + 5; k++) begin
            w = encode(4'($urandom_range(0, 15)));
            e = $urandom_range(0, 6);
            w[e] = ~w[e];
            send_frame(w, 0);
        end
        tick();
        check("sat_count", int'(corr_count), CMAX);
        out_ready = 1'b0;

        // Randomized frames, gaps and backpressure
        do_reset();
        rand_ready = 1;
        for (int k = 0; k < 300; k++) begin
            d = 4'($urandom_range(0, 15));
            w = encode(d);
            e = $urandom_range(0, 7);
            if (e != 0) w[e-1] = ~w[e-1];
            send_frame(w, 2);
        end
        rand_ready = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("rnd_drained", int'(fifo_level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
